// File: rtl/hv_seq_pkg.sv
// Shared types for the hypervector bundle sequencer and its element kernel.
//   HV_ADDR_W      : word-address width of the hypervector memories
//   hvseq_state_t  : bundle sequencer FSM states
//   hvkern_state_t : element kernel handshake states
package hv_seq_pkg;

  localparam int HV_ADDR_W = 21;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_CLEAR,
    S_DONE,
    S_ERROR
  } hvseq_state_t;

  // Element kernel: idle, computing one element, holding its done level.
  typedef enum logic [1:0] {
    K_IDLE,
    K_RUN,
    K_HOLD
  } hvkern_state_t;

endpackage

// File: rtl/hv_seq_addr_gen.sv
// Element address generator for the bundle sequencer.
// Latches the three base addresses at the start of an operation, keeps the
// element index, and registers base + idx*ADDR_STRIDE for each operand.
//   clk, reset_n         : clock, async active-low reset
//   load                 : latch base_a/b/c and clear idx
//   issue                : register the current element addresses
//   advance              : step idx to the next element
//   base_a/b/c           : operand A/B and result base addresses
//   addr_a/b/c           : registered element addresses (held between issues)
//   last                 : idx is the final element
module hv_seq_addr_gen
  import hv_seq_pkg::*;
#(
  parameter int HYPERVECTOR_DIMENSIONS = 1000,
  parameter int ADDR_STRIDE            = 1
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 load,
  input  logic                 issue,
  input  logic                 advance,
  input  logic [HV_ADDR_W-1:0] base_a,
  input  logic [HV_ADDR_W-1:0] base_b,
  input  logic [HV_ADDR_W-1:0] base_c,
  output logic [HV_ADDR_W-1:0] addr_a,
  output logic [HV_ADDR_W-1:0] addr_b,
  output logic [HV_ADDR_W-1:0] addr_c,
  output logic                 last
);

  // A single-element vector still needs a one-bit index.
  localparam int IDX_W = (HYPERVECTOR_DIMENSIONS > 1) ? $clog2(HYPERVECTOR_DIMENSIONS) : 1;

  logic [IDX_W-1:0]     idx;
  logic [HV_ADDR_W-1:0] base_a_q;
  logic [HV_ADDR_W-1:0] base_b_q;
  logic [HV_ADDR_W-1:0] base_c_q;
  logic [HV_ADDR_W-1:0] offset;

  // Offset and sums wrap at the address width.
  assign offset = HV_ADDR_W'(idx) * HV_ADDR_W'(ADDR_STRIDE);
  assign last   = (idx == IDX_W'(HYPERVECTOR_DIMENSIONS - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      idx      <= '0;
      base_a_q <= '0;
      base_b_q <= '0;
      base_c_q <= '0;
      addr_a   <= '0;
      addr_b   <= '0;
      addr_c   <= '0;
    end else begin
      if (load) begin
        base_a_q <= base_a;
        base_b_q <= base_b;
        base_c_q <= base_c;
        idx      <= '0;
      end else if (advance) begin
        idx <= idx + 1'b1;
      end
      if (issue) begin
        addr_a <= base_a_q + offset;
        addr_b <= base_b_q + offset;
        addr_c <= base_c_q + offset;
      end
    end
  end

endmodule

// File: rtl/hv_bundle_sequencer.sv
// Hypervector bundle sequencer: walks HYPERVECTOR_DIMENSIONS elements through
// an external element kernel, one issue/wait/clear round per element, with a
// per-element timeout.
//   clk, reset_n              : clock, async active-low reset
//   start, abort              : begin a whole-vector bundle / cancel it
//   base_a/b/c                : operand A/B and result base addresses
//   busy, done, error         : in progress / completion pulse / sticky timeout
//   kern_valid                : one-cycle element issue to the kernel
//   kern_addr_a/b/c           : element addresses for the kernel
//   kern_done                 : kernel completion level (held until cleared)
//   kern_rst_n                : registered active-low kernel clear
//
// state   | meaning
// S_IDLE  | waiting for start; bases latched on accept
// S_ISSUE | present element addresses, pulse kern_valid, clear timer
// S_WAIT  | wait for kern_done, count timeout
// S_CLEAR | pulse kern_rst_n low, step to next element or finish
// S_DONE  | pulse done, drop busy
// S_ERROR | kernel timed out; error held until abort or reset
//
// Every output is a register loaded from the decode of the current state, so
// outputs appear one cycle after the state that produces them. Abort bypasses
// this and clears the outputs on the same edge that returns the FSM to idle.
module hv_bundle_sequencer
  import hv_seq_pkg::*;
#(
  parameter int HYPERVECTOR_DIMENSIONS = 1000,
  parameter int ADDR_STRIDE            = 1,
  parameter int TIMEOUT_CYCLES         = 32
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 start,
  input  logic                 abort,
  input  logic [HV_ADDR_W-1:0] base_a,
  input  logic [HV_ADDR_W-1:0] base_b,
  input  logic [HV_ADDR_W-1:0] base_c,
  output logic                 busy,
  output logic                 done,
  output logic                 error,
  output logic                 kern_valid,
  output logic [HV_ADDR_W-1:0] kern_addr_a,
  output logic [HV_ADDR_W-1:0] kern_addr_b,
  output logic [HV_ADDR_W-1:0] kern_addr_c,
  input  logic                 kern_done,
  output logic                 kern_rst_n
);

  localparam int TW = $clog2(TIMEOUT_CYCLES);
  // Timer value on the wait cycle whose increment reaches TIMEOUT_CYCLES-1.
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 2);

  hvseq_state_t  state, state_d;
  logic [TW-1:0] timer, timer_d;
  logic          busy_d, done_d, error_d, kern_valid_d, kern_rst_n_d;
  logic          accept, issue, advance, last;

  hv_seq_addr_gen #(
    .HYPERVECTOR_DIMENSIONS(HYPERVECTOR_DIMENSIONS),
    .ADDR_STRIDE           (ADDR_STRIDE)
  ) u_addr_gen (
    .clk    (clk),
    .reset_n(reset_n),
    .load   (accept),
    .issue  (issue),
    .advance(advance),
    .base_a (base_a),
    .base_b (base_b),
    .base_c (base_c),
    .addr_a (kern_addr_a),
    .addr_b (kern_addr_b),
    .addr_c (kern_addr_c),
    .last   (last)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= S_IDLE;
      timer      <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b0;
      kern_valid <= 1'b0;
      kern_rst_n <= 1'b0;
    end else begin
      state      <= state_d;
      timer      <= timer_d;
      busy       <= busy_d;
      done       <= done_d;
      error      <= error_d;
      kern_valid <= kern_valid_d;
      kern_rst_n <= kern_rst_n_d;
    end
  end

  always_comb begin
    state_d      = state;
    timer_d      = timer;
    busy_d       = busy;
    done_d       = 1'b0;
    error_d      = error;
    kern_valid_d = 1'b0;
    kern_rst_n_d = 1'b1;
    accept       = 1'b0;
    issue        = 1'b0;
    advance      = 1'b0;

    // Abort outranks everything, including a kern_done in the same cycle.
    if (abort && (state != S_IDLE)) begin
      state_d      = S_IDLE;
      timer_d      = '0;
      busy_d       = 1'b0;
      error_d      = 1'b0;
      kern_rst_n_d = 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start && !abort) begin
            accept  = 1'b1;
            busy_d  = 1'b1;
            state_d = S_ISSUE;
          end
        end
        S_ISSUE: begin
          issue        = 1'b1;
          kern_valid_d = 1'b1;
          timer_d      = '0;
          state_d      = S_WAIT;
        end
        S_WAIT: begin
          if (kern_done) begin
            state_d = S_CLEAR;
          end else begin
            timer_d = timer + 1'b1;
            if (timer == TIMER_LAST) state_d = S_ERROR;
          end
        end
        S_CLEAR: begin
          kern_rst_n_d = 1'b0;
          if (last) begin
            state_d = S_DONE;
          end else begin
            advance = 1'b1;
            state_d = S_ISSUE;
          end
        end
        S_DONE: begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end
        S_ERROR: begin
          busy_d       = 1'b0;
          error_d      = 1'b1;
          // error is still low only on the first error cycle: one clear pulse.
          kern_rst_n_d = error;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hv_bundle_sequencer.sv
module tb_hv_bundle_sequencer;

  logic        clk = 1'b0;
  logic        reset_n, start, abort, kern_done;
  logic [20:0] base_a, base_b, base_c;
  logic        busy, done, error, kern_valid, kern_rst_n;
  logic [20:0] kern_addr_a, kern_addr_b, kern_addr_c;

  hv_bundle_sequencer #(
    .HYPERVECTOR_DIMENSIONS(4),
    .ADDR_STRIDE           (1),
    .TIMEOUT_CYCLES        (32)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .start      (start),
    .abort      (abort),
    .base_a     (base_a),
    .base_b     (base_b),
    .base_c     (base_c),
    .busy       (busy),
    .done       (done),
    .error      (error),
    .kern_valid (kern_valid),
    .kern_addr_a(kern_addr_a),
    .kern_addr_b(kern_addr_b),
    .kern_addr_c(kern_addr_c),
    .kern_done  (kern_done),
    .kern_rst_n (kern_rst_n)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Kernel model: kern_done rises in the 7th cycle counting the kern_valid
  // cycle as the 1st, and is held until kern_rst_n is seen low.
  localparam int KLAT = 7;
  logic k_hang = 1'b0;
  int   kcnt;
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n || !kern_rst_n) begin
      kcnt      <= 0;
      kern_done <= 1'b0;
    end else if (kern_valid) begin
      kcnt <= 2;
    end else if (kcnt != 0 && !kern_done && !k_hang) begin
      kcnt <= kcnt + 1;
      if (kcnt + 1 >= KLAT) kern_done <= 1'b1;
    end
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  typedef struct {
    logic [20:0] a;
    logic [20:0] b;
    logic [20:0] c;
  } addr_t;

  addr_t exp_q[$];
  int    done_q[$];
  int    valid_cnt = 0;
  int    done_cnt = 0;
  int    rst_low_cnt = 0;

  task automatic push_exp(input logic [20:0] a, input logic [20:0] b, input logic [20:0] c);
    addr_t e;
    e.a = a; e.b = b; e.c = c;
    exp_q.push_back(e);
  endtask

  // Monitor: pops the scoreboard whenever the DUT issues or completes.
  always @(negedge clk) begin
    if (reset_n) begin
      if (!kern_rst_n) rst_low_cnt++;
      if (kern_valid) begin
        valid_cnt++;
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_kern_valid: addr_a=0x%0h with no issue expected", kern_addr_a);
        end else begin
          addr_t e;
          e = exp_q.pop_front();
          check("kern_addr_a", kern_addr_a, e.a);
          check("kern_addr_b", kern_addr_b, e.b);
          check("kern_addr_c", kern_addr_c, e.c);
        end
      end
      if (done) begin
        done_cnt++;
        if (done_q.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_done: done at cycle %0d with none expected", cyc);
        end else begin
          check("done_cycle", cyc, done_q.pop_front());
        end
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic do_start(input logic [20:0] a, input logic [20:0] b, input logic [20:0] c,
                          output int sc);
    base_a = a; base_b = b; base_c = c;
    start  = 1'b1;
    sc     = cyc;
    tick();
    start  = 1'b0;
  endtask

  task automatic wait_valid(input int target, input int budget, input string name);
    int n = 0;
    while (valid_cnt < target && n < budget) begin tick(); n++; end
    check(name, valid_cnt, target);
  endtask

  task automatic wait_done(input int target, input int budget, input string name);
    int n = 0;
    while (done_cnt < target && n < budget) begin tick(); n++; end
    check(name, done_cnt, target);
  endtask

  task automatic wait_kdone(input int budget, input string name);
    int n = 0;
    while (!kern_done && n < budget) begin tick(); n++; end
    check(name, kern_done, 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int sc, v0, d0, r0;
    reset_n = 1'b0; start = 1'b0; abort = 1'b0;
    base_a = '0; base_b = '0; base_c = '0;
    repeat (3) tick();
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_error", error, 0);
    check("rst_kern_valid", kern_valid, 0);
    check("rst_kern_rst_n", kern_rst_n, 0);
    check("rst_kern_addr_a", kern_addr_a, 0);
    reset_n = 1'b1;
    tick();
    check("rst_release_kern_rst_n", kern_rst_n, 1);

    // Run 1: D=4 basic sequence, done 38 cycles after start.
    push_exp(21'h100, 21'h200, 21'h300);
    push_exp(21'h101, 21'h201, 21'h301);
    push_exp(21'h102, 21'h202, 21'h302);
    push_exp(21'h103, 21'h203, 21'h303);
    v0 = valid_cnt; d0 = done_cnt; r0 = rst_low_cnt;
    do_start(21'h100, 21'h200, 21'h300, sc);
    done_q.push_back(sc + 38);
    check("run1_busy", busy, 1);
    wait_done(d0 + 1, 100, "run1_done_seen");
    check("run1_busy_at_done", busy, 0);
    check("run1_valid_count", valid_cnt - v0, 4);
    check("run1_clear_pulses", rst_low_cnt - r0, 4);
    tick();
    check("run1_done_one_cycle", done, 0);

    // Run 2: result address wraps; mid-run start with new bases is ignored.
    push_exp(21'h040, 21'h080, 21'h1FFFFE);
    push_exp(21'h041, 21'h081, 21'h1FFFFF);
    push_exp(21'h042, 21'h082, 21'h000000);
    push_exp(21'h043, 21'h083, 21'h000001);
    v0 = valid_cnt; d0 = done_cnt;
    do_start(21'h040, 21'h080, 21'h1FFFFE, sc);
    done_q.push_back(sc + 38);
    wait_valid(v0 + 2, 40, "run2_second_issue");
    begin
      int sc2;
      do_start(21'h555, 21'h666, 21'h777, sc2);
    end
    check("run2_busy_after_restart", busy, 1);
    wait_done(d0 + 1, 100, "run2_done_seen");
    check("run2_valid_count", valid_cnt - v0, 4);

    // Run 3: abort in element 2's wait, coincident with kern_done.
    push_exp(21'h010, 21'h020, 21'h030);
    push_exp(21'h011, 21'h021, 21'h031);
    v0 = valid_cnt; d0 = done_cnt;
    do_start(21'h010, 21'h020, 21'h030, sc);
    wait_valid(v0 + 2, 40, "run3_second_issue");
    wait_kdone(20, "run3_kern_done_seen");
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("run3_busy_after_abort", busy, 0);
    check("run3_kern_rst_n_after_abort", kern_rst_n, 0);
    check("run3_error_after_abort", error, 0);
    tick();
    check("run3_kern_rst_n_release", kern_rst_n, 1);
    repeat (20) tick();
    check("run3_no_more_issue", valid_cnt - v0, 2);
    check("run3_no_done", done_cnt - d0, 0);

    // Run 4: kernel never completes -> timeout 32 cycles after kern_valid.
    k_hang = 1'b1;
    push_exp(21'h500, 21'h600, 21'h700);
    v0 = valid_cnt; d0 = done_cnt;
    do_start(21'h500, 21'h600, 21'h700, sc);
    wait_valid(v0 + 1, 10, "run4_issue");
    repeat (31) tick();
    check("run4_error_before_timeout", error, 0);
    check("run4_busy_before_timeout", busy, 1);
    tick();
    check("run4_error_at_timeout", error, 1);
    check("run4_busy_at_timeout", busy, 0);
    check("run4_kern_clear_at_timeout", kern_rst_n, 0);
    tick();
    check("run4_error_sticky", error, 1);
    check("run4_kern_clear_one_cycle", kern_rst_n, 1);
    begin
      int sc3;
      do_start(21'h0AA, 21'h0BB, 21'h0CC, sc3);
    end
    repeat (3) tick();
    check("run4_start_ignored_busy", busy, 0);
    check("run4_start_ignored_issue", valid_cnt - v0, 1);
    check("run4_no_done", done_cnt - d0, 0);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("run4_error_cleared", error, 0);
    check("run4_busy_after_abort", busy, 0);
    k_hang = 1'b0;
    tick();

    // start together with abort in idle does not start.
    v0 = valid_cnt;
    start = 1'b1; abort = 1'b1;
    tick();
    start = 1'b0; abort = 1'b0;
    check("start_abort_busy", busy, 0);
    repeat (4) tick();
    check("start_abort_no_issue", valid_cnt - v0, 0);

    // Run 5: reset during element 1, then a fresh normal run.
    push_exp(21'h123, 21'h234, 21'h345);
    v0 = valid_cnt; d0 = done_cnt;
    do_start(21'h123, 21'h234, 21'h345, sc);
    wait_valid(v0 + 1, 10, "run5_issue");
    repeat (2) tick();
    #2 reset_n = 1'b0;
    #1;
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    check("midrst_error", error, 0);
    check("midrst_kern_valid", kern_valid, 0);
    check("midrst_kern_rst_n", kern_rst_n, 0);
    check("midrst_addr_a", kern_addr_a, 0);
    check("midrst_addr_b", kern_addr_b, 0);
    check("midrst_addr_c", kern_addr_c, 0);
    tick();
    reset_n = 1'b1;
    tick();
    check("midrst_kern_rst_n_release", kern_rst_n, 1);
    check("midrst_no_done", done_cnt - d0, 0);

    push_exp(21'h7F0, 21'h7F8, 21'h800);
    push_exp(21'h7F1, 21'h7F9, 21'h801);
    push_exp(21'h7F2, 21'h7FA, 21'h802);
    push_exp(21'h7F3, 21'h7FB, 21'h803);
    v0 = valid_cnt;
    do_start(21'h7F0, 21'h7F8, 21'h800, sc);
    done_q.push_back(sc + 38);
    wait_done(d0 + 1, 100, "run6_done_seen");
    check("run6_valid_count", valid_cnt - v0, 4);
    repeat (3) tick();

    check("scoreboard_addr_empty", exp_q.size(), 0);
    check("scoreboard_done_empty", done_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/hv_bundle_sequencer.md
HV_BUNDLE_SEQUENCER -- requirements
Module: hv_bundle_sequencer

Interface
REQ-001 Parameter HYPERVECTOR_DIMENSIONS, 1000: number of elements processed per operation, minimum 1.
REQ-002 Parameter ADDR_STRIDE, 1: word-address increment between consecutive elements.
REQ-003 Parameter TIMEOUT_CYCLES, 32: maximum number of S_WAIT cycles allowed per element before an error is raised, minimum 2.
REQ-004 Port clk, input, 1: the single clock; all logic SHALL be clocked on the rising edge.
REQ-005 Port reset_n, input, 1: asynchronous active-low reset.
REQ-006 Port start, input, 1: one-cycle request to bundle a whole hypervector.
REQ-007 Port abort, input, 1: cancels the operation in progress.
REQ-008 Ports base_a, base_b, base_c, input, 21 each: base addresses of operand A, operand B and the result.
REQ-009 Port busy, output, 1: high while an operation is in progress.
REQ-010 Port done, output, 1: one-cycle pulse on successful completion.
REQ-011 Port error, output, 1: sticky kernel-timeout flag.
REQ-012 Port kern_valid, output, 1: one-cycle element-issue pulse to the element kernel.
REQ-013 Ports kern_addr_a, kern_addr_b, kern_addr_c, output, 21 each: element addresses presented to the kernel.
REQ-014 Port kern_done, input, 1: kernel completion level; the kernel holds it high until the kernel is reset.
REQ-015 Port kern_rst_n, output, 1: active-low kernel clear, driven by a register.

Function
REQ-016 All outputs SHALL be registered.
REQ-017 States SHALL be S_IDLE, S_ISSUE, S_WAIT, S_CLEAR, S_DONE and S_ERROR.
REQ-018 In S_IDLE, when start=1, the block SHALL latch base_a, base_b and base_c, set idx=0, set busy=1 and go to S_ISSUE on the next cycle.
REQ-019 In S_ISSUE, the block SHALL drive kern_valid=1 for exactly one cycle, drive kern_addr_x = base_x + idx*ADDR_STRIDE (modulo 2^21), clear the timer and go to S_WAIT.
REQ-020 kern_addr_a, kern_addr_b and kern_addr_c SHALL hold their values until the next S_ISSUE.
REQ-021 In S_WAIT, when kern_done=1, the block SHALL go to S_CLEAR.
REQ-022 In S_WAIT, when kern_done=0, the timer SHALL increment; on timer reaching TIMEOUT_CYCLES-1 with kern_done still 0, the block SHALL go to S_ERROR.
REQ-023 In S_CLEAR, the block SHALL drive kern_rst_n=0 for exactly one cycle.
REQ-024 In S_CLEAR, when idx==HYPERVECTOR_DIMENSIONS-1 the block SHALL go to S_DONE; otherwise it SHALL increment idx and go to S_ISSUE.
REQ-025 In S_DONE, the block SHALL drive done=1 for one cycle, drop busy and go to S_IDLE.
REQ-026 In S_ERROR, the block SHALL set error=1, drop busy, drive kern_rst_n=0 for one cycle and stay in S_ERROR until abort or reset.
REQ-027 In S_ERROR, start SHALL be ignored.
REQ-028 When abort=1 in any state other than S_IDLE, the block SHALL go next cycle to S_IDLE, with kern_rst_n=0 for one cycle, busy=0, done=0 and error cleared.
REQ-029 When abort and kern_done are both high in the same cycle, abort SHALL win.
REQ-030 start while busy=1 SHALL be ignored; base_x changes while busy=1 SHALL have no effect.
REQ-031 When start=1 and abort=1 together in S_IDLE, the block SHALL not start.
REQ-032 idx SHALL be $clog2(HYPERVECTOR_DIMENSIONS) bits wide; the address multiply-add SHALL be computed at 21 bits and truncated.
REQ-033 With the ElementAdditionCutBipolar_F kernel, per-element latency SHALL be 1 (S_ISSUE) + kernel latency + 1 (S_CLEAR) cycles.

Reset
REQ-034 On reset_n=0, the block SHALL asynchronously set state=S_IDLE, busy=0, done=0, error=0, kern_valid=0, kern_rst_n=0, kern_addr_a/b/c=0, idx=0 and timer=0.
REQ-035 kern_rst_n SHALL return to 1 on the first clock edge after reset_n deasserts, so the kernel is held in reset with this block.
REQ-036 Reset mid-operation SHALL abandon the operation with no done pulse.

Structure
REQ-037 The state enum hvseq_state_t and the address width constant HV_ADDR_W=21 SHALL live in shared package hv_seq_pkg, alongside the existing kernel state types.
REQ-038 One sub-module, hv_seq_addr_gen (idx counter plus three base+offset adders with registered outputs), SHALL be instantiated; the FSM and the timeout counter SHALL remain in hv_bundle_sequencer.

Verification
REQ-039 The bench SHALL cover: D=4, stride=1, bases 0x100/0x200/0x300, kernel model done after 7 cycles -> four kern_valid pulses at addr_a 0x100..0x103, matching b/c, each followed by a one-cycle kern_rst_n low, and a single done pulse 9*4+2 cycles after start.
REQ-040 The bench SHALL cover: base_c=0x1FFFFE, D=4 -> kern_addr_c sequence 0x1FFFFE, 0x1FFFFF, 0x000000, 0x000001.
REQ-041 The bench SHALL cover: kernel model never asserting done, TIMEOUT_CYCLES=32 -> error=1 and busy=0 exactly 32 cycles after kern_valid, no done; then abort -> error=0 and the block in S_IDLE.
REQ-042 The bench SHALL cover: abort in element 2's S_WAIT, coincident with kern_done -> no further kern_valid, busy=0 next cycle, no done.
REQ-043 The bench SHALL cover: start pulsed again mid-operation with new bases -> ignored, addresses unchanged.
REQ-044 The bench SHALL cover: reset_n asserted during element 1 -> all outputs at reset values immediately (asynchronously); a fresh start then runs to a normal done.
